arm_imm_encoder: RTL and testbench
==================================

ARM_IMM_ENCODER -- requirements
Module: arm_imm_encoder

Interface
REQ-001 Parameter: EARLY_EXIT, default 1, meaning: 1 = finish on first matching rotation; 0 = always scan all 16 rotations for constant latency.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to encode `value`; sampled only in IDLE.
REQ-005 value  input  32  constant to encode as an ARM data-processing immediate.
REQ-006 busy  output  1  high in SEARCH and DONE states.
REQ-007 done  output  1  one-cycle pulse; result outputs valid from this cycle.
REQ-008 valid  output  1  1 = value is encodable; 0 = not encodable.
REQ-009 shift_operand  output  12  {rotate[3:0], imm8[7:0]}; decodes to imm8 rotated right by 2*rotate.

Function
REQ-010 The FSM SHALL have three states: IDLE, SEARCH, DONE.
REQ-011 IDLE with start=1 SHALL latch value, clear the rotation counter r to 0, and go to SEARCH; with start=0 it SHALL stay in IDLE.
REQ-012 Each SEARCH cycle SHALL test exactly one candidate c = latched value rotated left by 2*r (32-bit rotate, no bits lost).
REQ-013 A match SHALL be c[31:8]==0.
REQ-014 On the first match, the block SHALL record valid=1, rotate=r and imm8=c[7:0].
REQ-015 Later matches SHALL NOT overwrite the recorded result, so the smallest rotate is always reported.
REQ-016 With EARLY_EXIT=1, a match SHALL move the FSM to DONE on the next edge.
REQ-017 With EARLY_EXIT=0, SEARCH SHALL continue until r=15, then go to DONE.
REQ-018 SEARCH with r=15 and no recorded match SHALL go to DONE with valid=0 and shift_operand=12'h000.
REQ-019 SEARCH not exiting SHALL increment r; r SHALL never wrap inside one search.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 Latency: if start is sampled at edge k and the match is at rotation r, done SHALL be high in the cycle after edge k+r+2.
REQ-022 Latency for no match, or for EARLY_EXIT=0, SHALL be fixed: done in the cycle after edge k+17.
REQ-023 valid and shift_operand SHALL hold their values from the done cycle until the next accepted start.
REQ-024 At an accepted start, valid and shift_operand SHALL clear to 0.
REQ-025 start asserted in SEARCH or DONE SHALL be ignored, not queued.
REQ-026 A change on value after acceptance SHALL NOT affect the current search.
REQ-027 start=1 in the DONE cycle SHALL be ignored; start SHALL be accepted only from the next IDLE cycle.
REQ-028 Round-trip: for valid=1, (zero-extended imm8) rotated right by 2*rotate SHALL equal the latched value.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, r=0, busy=0, done=0, valid=0, shift_operand=0, and clear the latched value.
REQ-030 rst takes priority over start and over any in-flight search; an aborted search SHALL produce no done pulse.
REQ-031 The first start SHALL be accepted at the first edge with rst=0.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (IDLE/SEARCH/DONE, 2 bits) and the constants ROT_LAST=15 and IMM_W=8.
REQ-033 One combinational sub-module, arm_rol_even, SHALL provide the rotate: inputs 32-bit data and 4-bit r; output data rotated left by 2*r.
REQ-034 All registers SHALL be in the single clk domain; done and busy SHALL be registered outputs.

Verification
REQ-035 value=32'h000000FF, EARLY_EXIT=1 -> valid=1, shift_operand=12'h0FF, done at k+2.
REQ-036 value=32'hFF000000 -> valid=1, shift_operand=12'h4FF, done at k+6.
REQ-037 value=32'hF000000F -> valid=1, shift_operand=12'h2FF.
REQ-038 value=32'h00000000 -> valid=1, shift_operand=12'h000, done at k+2.
REQ-039 value=32'h00000101 -> valid=0, shift_operand=12'h000, done at k+17.
REQ-040 EARLY_EXIT=0 with value=32'hFF000000 -> shift_operand=12'h4FF, done at k+17.
REQ-041 rst pulsed at k+3 during a search -> no done pulse, all outputs 0.
REQ-042 start re-pulsed at k+1 -> ignored.
REQ-043 Every scenario SHALL also run the round-trip check of REQ-028.

Source files
------------

// File: rtl/arm_imm_encoder_pkg.sv
// Shared types and constants for the ARM immediate encoder.
package arm_imm_encoder_pkg;

    // Controller states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Last rotation index tried in one search.
    localparam logic [3:0] ROT_LAST = 4'd15;

    // Width of the immediate byte.
    localparam int IMM_W = 8;

endpackage

// File: rtl/arm_imm_encoder_rol_even.sv
// Combinational 32-bit rotate left by an even amount (2*r).
module arm_rol_even (
    input  logic [31:0] data,
    input  logic [3:0]  r,
    output logic [31:0] rotated
);

    logic [4:0] amt;
    logic [5:0] back_amt;

    // Rotate as a left shift OR'd with the wrapped-around high bits.
    always_comb begin
        amt      = {r, 1'b0};
        back_amt = 6'd32 - {1'b0, amt};
        rotated  = (data << amt) | (data >> back_amt);
    end

endmodule

// File: rtl/arm_imm_encoder.sv
// Sequential search for an ARM data-processing immediate encoding:
// one rotation candidate is tested per SEARCH cycle.
module arm_imm_encoder
    import arm_imm_encoder_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [11:0] shift_operand
);

    state_e             state_q, state_d;
    logic [3:0]         r_q, r_d;
    logic [31:0]        val_q, val_d;
    logic               found_q, found_d;
    logic [3:0]         rot_q, rot_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [11:0]        shop_q, shop_d;

    logic [31:0]        cand;
    logic               match;

    arm_rol_even u_rol (
        .data    (val_q),
        .r       (r_q),
        .rotated (cand)
    );

    // Candidate fits when everything above the low byte is zero.
    always_comb begin
        match = (cand[31:IMM_W] == '0);
    end

    // Next-state logic: a match is recorded at one edge and acted on at the
    // following one, so done lands r+2 edges after the accepted start.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        val_d   = val_q;
        found_d = found_q;
        rot_d   = rot_q;
        imm_d   = imm_q;
        last_d  = last_q;
        valid_d = valid_q;
        shop_d  = shop_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEARCH;
                    val_d   = value;
                    r_d     = '0;
                    found_d = 1'b0;
                    rot_d   = '0;
                    imm_d   = '0;
                    last_d  = 1'b0;
                    valid_d = 1'b0;
                    shop_d  = '0;
                end
            end
            ST_SEARCH: begin
                if ((EARLY_EXIT && found_q) || last_q) begin
                    state_d = ST_DONE;
                    valid_d = found_q;
                    shop_d  = found_q ? {rot_q, imm_q} : 12'h000;
                end else begin
                    // Only the first match is kept: smallest rotate wins.
                    if (match && !found_q) begin
                        found_d = 1'b1;
                        rot_d   = r_q;
                        imm_d   = cand[IMM_W-1:0];
                    end
                    // Counter saturates at the last rotation; never wraps.
                    if (r_q == ROT_LAST) begin
                        last_d = 1'b1;
                    end else begin
                        r_d = r_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered copies of the upcoming state.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            val_q   <= '0;
            found_q <= 1'b0;
            rot_q   <= '0;
            imm_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            shop_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            val_q   <= val_d;
            found_q <= found_d;
            rot_q   <= rot_d;
            imm_q   <= imm_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            shop_q  <= shop_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign valid         = valid_q;
    assign shift_operand = shop_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// Self-checking bench: two encoders (early exit on/off) driven in parallel.
module tb_arm_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] value;

    logic        busy1, done1, valid1;
    logic [11:0] sh1;
    logic        busy0, done0, valid0;
    logic [11:0] sh0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arm_imm_encoder #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy1), .done(done1), .valid(valid1), .shift_operand(sh1)
    );

    arm_imm_encoder #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy0), .done(done0), .valid(valid0), .shift_operand(sh0)
    );

    typedef struct {
        logic [31:0] v;
        bit          ok;
        logic [11:0] sh;
        int          lat;
        bit          repulse;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
        logic [63:0] d;
        d = {v, v} >> n;
        return d[31:0];
    endfunction

    // Brute force over every (rotate, imm8) pair; keeps the smallest rotate.
    function automatic void model(input logic [31:0] v, output bit ok, output logic [11:0] sh);
        ok = 1'b0;
        sh = 12'h000;
        for (int rot = 15; rot >= 0; rot--) begin
            for (int imm = 0; imm < 256; imm++) begin
                if (ror32(32'(imm), 2 * rot) == v) begin
                    ok = 1'b1;
                    sh = {rot[3:0], imm[7:0]};
                end
            end
        end
    endfunction

    // One encode transaction on both DUTs, checking latency, results,
    // round-trip and hold after done.
    task automatic run_txn(input logic [31:0] v, input bit exp_ok, input logic [11:0] exp_sh,
                           input int exp_lat, input bit repulse, input string tag);
        int d1, d0, c1, c0;
        logic        cv1, cv0;
        logic [11:0] csh1, csh0;
        d1 = 0; d0 = 0; c1 = 0; c0 = 0;
        cv1 = 1'b0; cv0 = 1'b0; csh1 = '0; csh0 = '0;
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        value = $urandom;
        chk({tag, "_busy_at_start"}, {31'd0, busy1}, 32'd1);
        chk({tag, "_valid_clr"}, {19'd0, valid1, sh1}, 32'd0);
        if (repulse) begin
            start = 1'b1;
            value = 32'h0000_0101;
        end
        for (int n = 1; n <= 19; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
            if (done1) begin
                c1++;
                if (d1 == 0) begin d1 = n; cv1 = valid1; csh1 = sh1; end
            end
            if (done0) begin
                c0++;
                if (d0 == 0) begin d0 = n; cv0 = valid0; csh0 = sh0; end
            end
        end
        $display("txn %s value=%h ee1: done@k+%0d valid=%0d sh=%h ee0: done@k+%0d valid=%0d sh=%h",
                 tag, v, d1, cv1, csh1, d0, cv0, csh0);
        chk({tag, "_lat_ee1"}, d1, exp_lat);
        chk({tag, "_lat_ee0"}, d0, 17);
        chk({tag, "_pulses"}, {c1[15:0], c0[15:0]}, {16'd1, 16'd1});
        chk({tag, "_res_ee1"}, {19'd0, cv1, csh1}, {19'd0, exp_ok, exp_sh});
        chk({tag, "_res_ee0"}, {19'd0, cv0, csh0}, {19'd0, exp_ok, exp_sh});
        if (cv1) chk({tag, "_roundtrip"}, ror32({24'd0, csh1[7:0]}, 2 * int'(csh1[11:8])), v);
        chk({tag, "_hold"}, {6'd0, busy1, busy0, valid1, valid0, sh1, sh0},
            {6'd0, 1'b0, 1'b0, exp_ok, exp_ok, exp_sh, exp_sh});
    endtask

    vec_t vecs[6];

    initial begin
        vec_t        t;
        bit          ok;
        logic [11:0] sh;
        logic [31:0] v;
        int          cnt;

        vecs[0] = '{v: 32'h0000_00FF, ok: 1'b1, sh: 12'h0FF, lat: 2,  repulse: 1'b0};
        vecs[1] = '{v: 32'hFF00_0000, ok: 1'b1, sh: 12'h4FF, lat: 6,  repulse: 1'b0};
        vecs[2] = '{v: 32'hF000_000F, ok: 1'b1, sh: 12'h2FF, lat: 4,  repulse: 1'b0};
        vecs[3] = '{v: 32'h0000_0000, ok: 1'b1, sh: 12'h000, lat: 2,  repulse: 1'b0};
        vecs[4] = '{v: 32'h0000_0101, ok: 1'b0, sh: 12'h000, lat: 17, repulse: 1'b0};
        vecs[5] = '{v: 32'hFF00_0000, ok: 1'b1, sh: 12'h4FF, lat: 6,  repulse: 1'b1};

        // Reset with start held high: reset wins.
        rst = 1'b1; start = 1'b1; value = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {26'd0, busy1, done1, valid1, busy0, done0, valid0}, 32'd0);
        chk("reset_shop", {8'd0, sh1, sh0}, 32'd0);

        // First start accepted at the first edge with rst low.
        @(negedge clk);
        rst = 1'b0; value = 32'h0000_00FF;
        @(posedge clk); #1;
        start = 1'b0;
        chk("first_start_busy", {31'd0, busy1}, 32'd1);
        repeat (20) @(posedge clk);

        // Directed table.
        foreach (vecs[i]) begin
            t = vecs[i];
            run_txn(t.v, t.ok, t.sh, t.lat, t.repulse, $sformatf("vec%0d", i));
        end

        // Randomized, half drawn from encodable values.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1)
                v = ror32({24'd0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
            else
                v = $urandom;
            model(v, ok, sh);
            run_txn(v, ok, sh, ok ? int'(sh[11:8]) + 2 : 17, 1'b0, $sformatf("rnd%0d", i));
        end

        // Start held high through the DONE cycle: ignored there, accepted next IDLE.
        @(negedge clk);
        value = 32'h0000_00FF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("done_cycle", {30'd0, done1, valid1}, 32'd3);
        start = 1'b1; value = 32'h0000_0101;
        @(posedge clk); #1;
        chk("start_in_done_ignored", {19'd0, busy1, valid1, sh1}, {19'd0, 1'b0, 1'b1, 12'h0FF});
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_next_idle", {30'd0, busy1, valid1}, 32'd2);
        $display("txn start_in_done busy=%0d valid=%0d sh=%h", busy1, valid1, sh1);
        repeat (20) @(posedge clk);
        #1;
        chk("start_next_idle_res", {19'd0, valid1, sh1}, 32'd0);

        // Reset mid-search: no done pulse and everything cleared.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        value = 32'hFF00_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_outputs", {8'd0, busy1, done1, valid1, busy0, done0, valid0, sh1, sh0}, 32'd0);
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done1 || done0) cnt++;
        end
        $display("txn abort done_pulses=%0d", cnt);
        chk("abort_no_done", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
